// File: rtl/seq_detector_param.sv
// Serial pattern detector: PAT_W-bit pattern on a qualified bit stream, overlap/non-overlap at run time.
// Latency: match pulses one cycle after the edge that samples the final pattern bit.
// Backpressure: none; din is taken only when din_valid is high, and idle cycles leave the history untouched.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clear           synchronous clear of history, fill, counter (and pattern load, see below)
//   din_valid, din  qualified serial input bit
//   overlap         1 = overlapping matches, 0 = bits used by a match are consumed
//   match           registered one-cycle pulse per detected pattern
//   match_cnt       saturating match count; cnt_sat high while it sits at all-ones
// Optional build macro SEQ_DETECTOR_RUNTIME_PAT_EN adds input pat_i[PAT_W]: a pattern register,
// reset to PATTERN and loaded from pat_i whenever clear is high, replaces the PATTERN constant.
module seq_detector_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              din_valid,
    input  logic              din,
    input  logic              overlap,
`ifdef SEQ_DETECTOR_RUNTIME_PAT_EN
    input  logic [PAT_W-1:0]  pat_i,
`endif
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_cur;

    logic [PAT_W-1:0]  cand;
    logic              accept;
    logic              hit;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sat_nxt;
    logic [CNT_W-1:0]  cnt_inc;

`ifdef SEQ_DETECTOR_RUNTIME_PAT_EN
    logic [PAT_W-1:0] pat_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg <= PATTERN;
        end else if (clear) begin
            pat_reg <= pat_i;
        end
    end

    assign pat_cur = pat_reg;
`else
    assign pat_cur = PATTERN;
`endif

    assign cand    = {hist[PAT_W-2:0], din};
    assign accept  = din_valid & ~clear;
    // fill >= PAT_W-1 means the PAT_W-1 older bits of cand are all eligible.
    assign hit     = accept & (fill >= FILL_ARM) & (cand == pat_cur);
    assign cnt_inc = match_cnt + CNT_W'(1);

    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        cnt_nxt  = match_cnt;
        sat_nxt  = cnt_sat;
        if (clear) begin
            hist_nxt = '0;
            fill_nxt = '0;
            cnt_nxt  = '0;
            sat_nxt  = 1'b0;
        end else if (din_valid) begin
            hist_nxt = cand;
            fill_nxt = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
            if (hit) begin
                // Non-overlapping: forget eligibility so consumed bits cannot seed
                // the next match. Overlapping: fill is already saturated above.
                if (!overlap) begin
                    fill_nxt = '0;
                end
                if (match_cnt != CNT_MAX) begin
                    cnt_nxt = cnt_inc;
                    sat_nxt = (cnt_inc == CNT_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            hist      <= hist_nxt;
            fill      <= fill_nxt;
            match     <= hit;
            match_cnt <= cnt_nxt;
            cnt_sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: a default instance and a CNT_W=2 instance share stimulus.
// Expected values come from a queue-based model of the eligible bit stream.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_seq_detector_param;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PAT   = 4'b1011;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       din_valid;
    logic       din;
    logic       overlap;
    logic       match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sat_a, sat_b;
`ifdef SEQ_DETECTOR_RUNTIME_PAT_EN
    logic [3:0] pat_i = PAT;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din),
        .overlap(overlap),
`ifdef SEQ_DETECTOR_RUNTIME_PAT_EN
        .pat_i(pat_i),
`endif
        .match(match_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din),
        .overlap(overlap),
`ifdef SEQ_DETECTOR_RUNTIME_PAT_EN
        .pat_i(pat_i),
`endif
        .match(match_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the most recent eligible bits (oldest first), counts, pulse.
    bit q[$];
    int m_cnt_a = 0;
    int m_cnt_b = 0;
    bit m_match = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_match = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit v, input bit d, input bit c, input bit ov);
        int w;
        m_match = 1'b0;
        if (c) begin
            q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (v) begin
            q.push_back(d);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() == PAT_W) begin
                w = 0;
                foreach (q[i]) w = (w << 1) | int'(q[i]);
                if (w == int'(PAT)) begin
                    m_match = 1'b1;
                    if (m_cnt_a < 255) m_cnt_a++;
                    if (m_cnt_b < 3)   m_cnt_b++;
                    if (!ov) q.delete();
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_match_a"}, 32'(match_a), 32'(m_match));
        chk({tag, "_match_b"}, 32'(match_b), 32'(m_match));
        chk({tag, "_cnt_a"},   32'(cnt_a),   32'(m_cnt_a));
        chk({tag, "_cnt_b"},   32'(cnt_b),   32'(m_cnt_b));
        chk({tag, "_sat_a"},   32'(sat_a),   32'(m_cnt_a == 255));
        chk({tag, "_sat_b"},   32'(sat_b),   32'(m_cnt_b == 3));
    endtask

    task automatic step(input bit v, input bit d, input bit c, input bit ov, input string tag);
        din_valid = v;
        din       = d;
        clear     = c;
        overlap   = ov;
        @(posedge clk);
        model_edge(v, d, c, ov);
        #1;
        check_outputs(tag);
    endtask

    // Send n bits MSB first, with 'gap' invalid cycles after each bit.
    task automatic send(input logic [31:0] bits, input int n, input bit ov, input int gap,
                        input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, ov, tag);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, ov, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_match"}, 32'(match_a), 32'd0);
        chk({tag, "_rst_cnt"},   32'(cnt_a),   32'd0);
        chk({tag, "_rst_sat"},   32'(sat_b),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        overlap   = 1'b0;
        #2;
        chk("reset_match", 32'(match_a), 32'd0);
        chk("reset_cnt_a", 32'(cnt_a),   32'd0);
        chk("reset_cnt_b", 32'(cnt_b),   32'd0);
        chk("reset_sat",   32'(sat_b),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Overlapping: 1011011 gives two matches.
        step(1'b0, 1'b0, 1'b1, 1'b1, "tp1_clr");
        send(32'b1011011, 7, 1'b1, 0, "tp1");
        chk("tp1_total", 32'(cnt_a), 32'd2);

        // Non-overlapping: same stream gives one match.
        step(1'b0, 1'b0, 1'b1, 1'b0, "tp2_clr");
        send(32'b1011011, 7, 1'b0, 0, "tp2");
        chk("tp2_total", 32'(cnt_a), 32'd1);

        // Gaps between valid bits are transparent.
        step(1'b0, 1'b0, 1'b1, 1'b1, "tp3_clr");
        send(32'b1011, 4, 1'b1, 3, "tp3");
        chk("tp3_total", 32'(cnt_a), 32'd1);

        // Saturation of the 2-bit counter with four overlapping matches.
        step(1'b0, 1'b0, 1'b1, 1'b1, "tp4_clr");
        send(32'b1011011011011, 13, 1'b1, 0, "tp4");
        chk("tp4_cnt_b", 32'(cnt_b), 32'd3);
        chk("tp4_sat_b", 32'(sat_b), 32'd1);
        chk("tp4_cnt_a", 32'(cnt_a), 32'd4);

        // Reset mid-stream discards partial history.
        step(1'b0, 1'b0, 1'b1, 1'b1, "tp5_clr");
        send(32'b101, 3, 1'b1, 0, "tp5a");
        do_reset("tp5");
        send(32'b1011, 4, 1'b1, 0, "tp5b");
        chk("tp5_total", 32'(cnt_a), 32'd1);

        // A hit coinciding with clear is discarded.
        step(1'b0, 1'b0, 1'b1, 1'b1, "tp6_clr");
        send(32'b101, 3, 1'b1, 0, "tp6a");
        step(1'b1, 1'b1, 1'b1, 1'b1, "tp6_hitclr");
        chk("tp6_nopulse", 32'(match_a), 32'd0);
        chk("tp6_cnt0",    32'(cnt_a),   32'd0);
        send(32'b1011, 4, 1'b1, 0, "tp6b");
        chk("tp6_total", 32'(cnt_a), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd");
            end else begin
                step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 99) < 2),
                     1'($urandom), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
